// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: merges ALU and LSB results onto one registered
// write-back port, with a small bypassable FIFO per source.
module cdb_fifo #(
    parameter int W  = 37,
    parameter int DB = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [DB:0]   count,
    output logic          full
);
    localparam int D = 1 << DB;

    logic [W-1:0]  mem [D];
    logic [DB-1:0] rd_ptr;
    logic [DB-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // A full queue refuses pushes even when it pops in the same cycle.
    assign full    = (count == (DB+1)'(D));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

module cdb_arbiter #(
    parameter int ROB_WIDTH_BIT  = 5,
    parameter int FIFO_DEPTH_BIT = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear_in,
    input  logic                     alu_valid,
    input  logic [ROB_WIDTH_BIT-1:0] alu_rob_id,
    input  logic [31:0]              alu_val,
    output logic                     alu_full,
    input  logic                     lsb_valid,
    input  logic                     lsb_has_val,
    input  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id,
    input  logic [31:0]              lsb_val,
    output logic                     lsb_full,
    output logic                     cdb_valid,
    output logic                     cdb_src,
    output logic                     cdb_has_val,
    output logic [ROB_WIDTH_BIT-1:0] cdb_rob_id,
    output logic [31:0]              cdb_val,
    output logic                     overflow_err
);
    localparam int AW = ROB_WIDTH_BIT + 32;
    localparam int LW = AW + 1;

    logic [AW-1:0]           alu_head;
    logic [LW-1:0]           lsb_head;
    logic [FIFO_DEPTH_BIT:0] alu_cnt;
    logic [FIFO_DEPTH_BIT:0] lsb_cnt;
    logic                    alu_q_full;
    logic                    lsb_q_full;
    logic                    last_grant;

    logic run;
    logic flush;
    logic alu_from_q;
    logic lsb_from_q;
    logic alu_cand;
    logic lsb_cand;
    logic grant_alu;
    logic grant_lsb;
    logic alu_push;
    logic lsb_push;
    logic alu_pop;
    logic lsb_pop;
    logic alu_ovf;
    logic lsb_ovf;

    logic [ROB_WIDTH_BIT-1:0] alu_sel_id;
    logic [31:0]              alu_sel_val;
    logic                     lsb_sel_hv;
    logic [ROB_WIDTH_BIT-1:0] lsb_sel_id;
    logic [31:0]              lsb_sel_val;

    assign run   = rdy_in && !clear_in;
    assign flush = rdy_in && clear_in;

    assign alu_from_q = (alu_cnt != '0);
    assign lsb_from_q = (lsb_cnt != '0);
    assign alu_cand   = alu_from_q || alu_valid;
    assign lsb_cand   = lsb_from_q || lsb_valid;

    // last_grant: 0 = ALU, 1 = LSB; on a tie the other source wins.
    assign grant_alu = alu_cand && (!lsb_cand || last_grant);
    assign grant_lsb = lsb_cand && !grant_alu;

    assign alu_push = run && alu_valid && !(grant_alu && !alu_from_q);
    assign lsb_push = run && lsb_valid && !(grant_lsb && !lsb_from_q);
    assign alu_pop  = run && grant_alu && alu_from_q;
    assign lsb_pop  = run && grant_lsb && lsb_from_q;

    assign alu_ovf = run && alu_valid && alu_q_full;
    assign lsb_ovf = run && lsb_valid && lsb_q_full;

    assign alu_full = alu_q_full || !rdy_in;
    assign lsb_full = lsb_q_full || !rdy_in;

    assign alu_sel_id  = alu_from_q ? alu_head[AW-1:32] : alu_rob_id;
    assign alu_sel_val = alu_from_q ? alu_head[31:0]    : alu_val;
    assign lsb_sel_hv  = lsb_from_q ? lsb_head[LW-1]    : lsb_has_val;
    assign lsb_sel_id  = lsb_from_q ? lsb_head[AW-1:32] : lsb_rob_id;
    assign lsb_sel_val = lsb_from_q ? lsb_head[31:0]    : lsb_val;

    cdb_fifo #(.W(AW), .DB(FIFO_DEPTH_BIT)) u_alu_q (
        .clk   (clk_in),
        .rst   (rst_in),
        .flush (flush),
        .push  (alu_push),
        .pop   (alu_pop),
        .din   ({alu_rob_id, alu_val}),
        .head  (alu_head),
        .count (alu_cnt),
        .full  (alu_q_full)
    );

    cdb_fifo #(.W(LW), .DB(FIFO_DEPTH_BIT)) u_lsb_q (
        .clk   (clk_in),
        .rst   (rst_in),
        .flush (flush),
        .push  (lsb_push),
        .pop   (lsb_pop),
        .din   ({lsb_has_val, lsb_rob_id, lsb_val}),
        .head  (lsb_head),
        .count (lsb_cnt),
        .full  (lsb_q_full)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_grant   <= 1'b1;
            cdb_valid    <= 1'b0;
            cdb_src      <= 1'b0;
            cdb_has_val  <= 1'b0;
            cdb_rob_id   <= '0;
            cdb_val      <= '0;
            overflow_err <= 1'b0;
        end else if (rdy_in) begin
            if (clear_in) begin
                cdb_valid  <= 1'b0;
                last_grant <= 1'b1;
            end else begin
                overflow_err <= overflow_err | alu_ovf | lsb_ovf;
                unique case (1'b1)
                    grant_alu: begin
                        cdb_valid   <= 1'b1;
                        cdb_src     <= 1'b0;
                        cdb_has_val <= 1'b1;
                        cdb_rob_id  <= alu_sel_id;
                        cdb_val     <= alu_sel_val;
                        last_grant  <= 1'b0;
                    end
                    grant_lsb: begin
                        cdb_valid   <= 1'b1;
                        cdb_src     <= 1'b1;
                        cdb_has_val <= lsb_sel_hv;
                        cdb_rob_id  <= lsb_sel_id;
                        cdb_val     <= lsb_sel_val;
                        last_grant  <= 1'b1;
                    end
                    default: begin
                        cdb_valid   <= 1'b0;
                        cdb_src     <= 1'b0;
                        cdb_has_val <= 1'b0;
                        cdb_rob_id  <= '0;
                        cdb_val     <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: expected broadcasts are queued in
// hand-computed arbitration order and a negedge monitor checks each one.
module tb_cdb_arbiter;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdy = 1'b1;
    logic          clr = 1'b0;
    logic          alu_valid = 1'b0;
    logic [RW-1:0] alu_rob_id = '0;
    logic [31:0]   alu_val = '0;
    logic          alu_full;
    logic          lsb_valid = 1'b0;
    logic          lsb_has_val = 1'b0;
    logic [RW-1:0] lsb_rob_id = '0;
    logic [31:0]   lsb_val = '0;
    logic          lsb_full;
    logic          cdb_valid;
    logic          cdb_src;
    logic          cdb_has_val;
    logic [RW-1:0] cdb_rob_id;
    logic [31:0]   cdb_val;
    logic          overflow_err;

    typedef struct packed {
        logic          src;
        logic          hv;
        logic [RW-1:0] id;
        logic [31:0]   val;
    } ent_t;

    ent_t expq[$];
    int   tests = 0;
    int   fails = 0;
    logic last_rdy = 1'b0;

    cdb_arbiter #(.ROB_WIDTH_BIT(RW), .FIFO_DEPTH_BIT(2)) dut (
        .clk_in       (clk),
        .rst_in       (rst),
        .rdy_in       (rdy),
        .clear_in     (clr),
        .alu_valid    (alu_valid),
        .alu_rob_id   (alu_rob_id),
        .alu_val      (alu_val),
        .alu_full     (alu_full),
        .lsb_valid    (lsb_valid),
        .lsb_has_val  (lsb_has_val),
        .lsb_rob_id   (lsb_rob_id),
        .lsb_val      (lsb_val),
        .lsb_full     (lsb_full),
        .cdb_valid    (cdb_valid),
        .cdb_src      (cdb_src),
        .cdb_has_val  (cdb_has_val),
        .cdb_rob_id   (cdb_rob_id),
        .cdb_val      (cdb_val),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    // Outputs only change on edges where rdy was high and reset was low.
    always @(posedge clk) last_rdy <= rdy && !rst;

    always @(negedge clk) begin
        ent_t e;
        ent_t g;
        if (last_rdy && cdb_valid) begin
            g = '{src: cdb_src, hv: cdb_has_val, id: cdb_rob_id, val: cdb_val};
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL cdb_unexpected got=%h required=none", g);
            end else begin
                e = expq.pop_front();
                if (g !== e) begin
                    fails++;
                    $display("FAIL cdb_entry got=%h required=%h", g, e);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h required=%h", nm, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setin(input logic av, input logic [RW-1:0] aid,
                         input logic [31:0] aval, input logic lv,
                         input logic lh, input logic [RW-1:0] lid,
                         input logic [31:0] lval);
        alu_valid   = av;
        alu_rob_id  = aid;
        alu_val     = aval;
        lsb_valid   = lv;
        lsb_has_val = lh;
        lsb_rob_id  = lid;
        lsb_val     = lval;
    endtask

    task automatic idle();
        setin(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic expa(input logic [RW-1:0] id, input logic [31:0] val);
        expq.push_back('{src: 1'b0, hv: 1'b1, id: id, val: val});
    endtask

    task automatic expl(input logic hv, input logic [RW-1:0] id,
                        input logic [31:0] val);
        expq.push_back('{src: 1'b1, hv: hv, id: id, val: val});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdy = 1'b1;
        clr = 1'b0;
        idle();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_valid", 32'(cdb_valid), 32'd0);
        check("rst_src", 32'(cdb_src), 32'd0);
        check("rst_has_val", 32'(cdb_has_val), 32'd0);
        check("rst_rob_id", 32'(cdb_rob_id), 32'd0);
        check("rst_val", cdb_val, 32'd0);
        check("rst_ovf", 32'(overflow_err), 32'd0);
        check("rst_alu_full", 32'(alu_full), 32'd0);
        check("rst_lsb_full", 32'(lsb_full), 32'd0);

        // Single ALU result, one-cycle latency.
        expa(5'd3, 32'h55);
        setin(1'b1, 5'd3, 32'h55, 1'b0, 1'b0, '0, '0);
        cyc();
        idle();
        check("lat_valid", 32'(cdb_valid), 32'd1);
        cyc();
        check("lat_after", 32'(cdb_valid), 32'd0);
        cyc();
        check("single_drained", 32'(expq.size()), 32'd0);

        // Ties and round-robin, then a store completion.
        do_reset();
        expa(5'd1, 32'd10);
        expl(1'b1, 5'd2, 32'd20);
        expa(5'd4, 32'd40);
        expl(1'b1, 5'd5, 32'd50);
        expa(5'd6, 32'd60);
        expl(1'b1, 5'd8, 32'd80);
        expa(5'd7, 32'd70);
        expl(1'b0, 5'd9, 32'd0);
        setin(1'b1, 5'd1, 32'd10, 1'b1, 1'b1, 5'd2, 32'd20);
        cyc();
        idle();
        cyc();
        setin(1'b1, 5'd4, 32'd40, 1'b1, 1'b1, 5'd5, 32'd50);
        cyc();
        idle();
        cyc();
        setin(1'b1, 5'd6, 32'd60, 1'b0, 1'b0, '0, '0);
        cyc();
        setin(1'b1, 5'd7, 32'd70, 1'b1, 1'b1, 5'd8, 32'd80);
        cyc();
        idle();
        cyc();
        setin(1'b0, '0, '0, 1'b1, 1'b0, 5'd9, 32'd0);
        cyc();
        idle();
        cyc();
        cyc();
        check("tie_drained", 32'(expq.size()), 32'd0);

        // Backpressure: both streaming, fill, stall, then overflow.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            expa(5'(16 + k), 32'(32'h100 + k));
            expl(1'b1, 5'(k), 32'(32'h200 + k));
        end
        for (int k = 0; k < 7; k++) begin
            setin(1'b1, 5'(16 + k), 32'(32'h100 + k),
                  1'b1, 1'b1, 5'(k), 32'(32'h200 + k));
            cyc();
        end
        check("bp_lsb_full", 32'(lsb_full), 32'd1);
        check("bp_alu_notfull", 32'(alu_full), 32'd0);
        setin(1'b1, 5'd23, 32'h107, 1'b0, 1'b0, '0, '0);
        cyc();
        check("bp_alu_full", 32'(alu_full), 32'd1);
        check("bp_lsb_notfull", 32'(lsb_full), 32'd0);
        setin(1'b0, '0, '0, 1'b1, 1'b1, 5'd7, 32'h207);
        cyc();
        check("bp_lsb_full2", 32'(lsb_full), 32'd1);
        check("bp_ovf_before", 32'(overflow_err), 32'd0);
        setin(1'b0, '0, '0, 1'b1, 1'b1, 5'd8, 32'h208);
        cyc();
        idle();
        check("bp_ovf_set", 32'(overflow_err), 32'd1);
        for (int k = 0; k < 8; k++) cyc();
        check("bp_drained", 32'(expq.size()), 32'd0);
        check("bp_ovf_sticky", 32'(overflow_err), 32'd1);

        // Clear with three entries queued per source.
        for (int k = 0; k < 3; k++) begin
            expa(5'(24 + k), 32'(32'h300 + k));
            expl(1'b1, 5'(10 + k), 32'(32'h400 + k));
        end
        for (int k = 0; k < 6; k++) begin
            setin(1'b1, 5'(24 + k), 32'(32'h300 + k),
                  1'b1, 1'b1, 5'(10 + k), 32'(32'h400 + k));
            cyc();
        end
        clr = 1'b1;
        setin(1'b1, 5'd30, 32'h3ff, 1'b1, 1'b1, 5'd31, 32'h4ff);
        cyc();
        clr = 1'b0;
        idle();
        check("clr_valid", 32'(cdb_valid), 32'd0);
        check("clr_alu_full", 32'(alu_full), 32'd0);
        check("clr_lsb_full", 32'(lsb_full), 32'd0);
        check("clr_ovf_kept", 32'(overflow_err), 32'd1);
        for (int k = 0; k < 4; k++) cyc();
        expa(5'd1, 32'h11);
        expl(1'b1, 5'd2, 32'h22);
        setin(1'b1, 5'd1, 32'h11, 1'b1, 1'b1, 5'd2, 32'h22);
        cyc();
        idle();
        cyc();
        cyc();
        check("clr_drained", 32'(expq.size()), 32'd0);

        do_reset();
        check("ovf_cleared", 32'(overflow_err), 32'd0);

        // Pause with entries queued.
        for (int k = 0; k < 4; k++) begin
            expa(5'(12 + k), 32'(32'h500 + k));
            expl(1'b1, 5'(20 + k), 32'(32'h600 + k));
        end
        for (int k = 0; k < 4; k++) begin
            setin(1'b1, 5'(12 + k), 32'(32'h500 + k),
                  1'b1, 1'b1, 5'(20 + k), 32'(32'h600 + k));
            cyc();
        end
        for (int p = 0; p < 3; p++) begin
            rdy = 1'b0;
            setin(1'b1, 5'd30, 32'hdead, 1'b1, 1'b1, 5'd31, 32'hbeef);
            #1;
            check("pause_valid", 32'(cdb_valid), 32'd1);
            check("pause_rob_id", 32'(cdb_rob_id), 32'd21);
            check("pause_val", cdb_val, 32'h601);
            check("pause_alu_full", 32'(alu_full), 32'd1);
            check("pause_lsb_full", 32'(lsb_full), 32'd1);
            cyc();
        end
        rdy = 1'b1;
        idle();
        for (int k = 0; k < 6; k++) cyc();
        check("pause_drained", 32'(expq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single result write-back port into the reorder buffer between the RS/ALU execute end and the LSB execute end.
- Each source gets a small FIFO with a bypass path; a round-robin arbiter grants one result per cycle onto a registered CDB.
- The CDB drives the reorder buffer set interface and broadcasts to the RS/LSB wake-up logic.
- Flushes on branch-mispredict clear.

Parameters:
- ROB_WIDTH_BIT, 5, width of ROB entry ids.
- FIFO_DEPTH_BIT, 2, log2 of per-source FIFO depth (default depth 4).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; low pauses the block
- clear_in  input  1  mispredict flush from the reorder buffer
- alu_valid  input  1  ALU result valid
- alu_rob_id  input  ROB_WIDTH_BIT  ROB entry of ALU result
- alu_val  input  32  ALU result value
- alu_full  output  1  ALU FIFO cannot accept a push this cycle
- lsb_valid  input  1  LSB result valid
- lsb_has_val  input  1  1 = load (carries value), 0 = store completion
- lsb_rob_id  input  ROB_WIDTH_BIT  ROB entry of LSB result
- lsb_val  input  32  load data
- lsb_full  output  1  LSB FIFO cannot accept a push this cycle
- cdb_valid  output  1  registered: result broadcast this cycle
- cdb_src  output  1  registered: 0 = ALU, 1 = LSB
- cdb_has_val  output  1  registered: value field meaningful (ALU always 1)
- cdb_rob_id  output  ROB_WIDTH_BIT  registered: ROB id
- cdb_val  output  32  registered: result value
- overflow_err  output  1  sticky: push attempted while full

Behaviour:
- Reset (rst_in=1 at a clock edge):
  - Both FIFOs emptied; counts 0; last_grant = 1, so the ALU wins the first tie.
  - cdb_valid, cdb_src, cdb_has_val = 0; cdb_rob_id = 0; cdb_val = 0; overflow_err = 0.
  - Reset has priority over clear_in and rdy_in.
- rdy_in=0: all state and registered outputs hold. Inputs are ignored. alu_full and lsb_full are forced to 1 so producers stall.
- Clear (clear_in=1 and rdy_in=1):
  - FIFOs emptied; cdb_valid <= 0; last_grant <= 1.
  - Same-cycle inputs are discarded.
  - overflow_err is kept.
- Full flags are combinational: x_full = (count_x == 2^FIFO_DEPTH_BIT) or !rdy_in.
  - A full FIFO refuses a push even if it pops in the same cycle (conservative).
  - A push while full is dropped and sets overflow_err.
- Candidate per source:
  - the FIFO head if the count is nonzero;
  - otherwise the same-cycle input if valid (bypass);
  - otherwise none.
- Arbitration:
  - One candidate: it is granted.
  - Two candidates: grant the source != last_grant.
  - last_grant updates only on a grant.
- Grant effects:
  - The granted entry is written to the cdb_* registers with cdb_valid=1, visible the next cycle.
  - A granted FIFO head is popped.
  - A granted bypass input is not enqueued.
  - Non-granted valid inputs are pushed (if not full).
- Latency: an uncontended result appears on the CDB exactly 1 cycle after its valid.
- Order: FIFO order is preserved within a source. There is no ordering guarantee between sources.
- No grant: cdb_valid <= 0 and rob_id/val/src/has_val <= 0.
- Pointer wrap:
  - rd/wr pointers are FIFO_DEPTH_BIT wide and wrap modulo depth.
  - count is FIFO_DEPTH_BIT+1 wide.
  - Simultaneous push and pop keeps the count unchanged.
- Throughput: maximum 1 result per cycle. With both sources streaming every cycle, the FIFOs fill and backpressure via the full flags.

Test Plan:
- Single ALU: after reset, alu_valid=1, rob_id=3, val=0x55 for 1 cycle -> next cycle cdb_valid=1, src=0, has_val=1, rob_id=3, val=0x55; following cycle cdb_valid=0.
- Tie: both sources valid in the same cycle (ALU id 1 val 10; LSB id 2 load val 20) -> CDB shows ALU id 1, then LSB id 2 on consecutive cycles. A second simultaneous pair grants LSB first only if last_grant=0.
- Backpressure:
  - LSB valid every cycle, ids 0..7, while the ALU is also valid every cycle -> no result lost, per-source order kept.
  - lsb_full asserts when 4 entries are queued.
  - A forced push while full sets overflow_err, which stays 1 until rst_in.
- Store completion: lsb_valid=1, has_val=0, id 9 -> cdb_has_val=0, src=1, rob_id=9.
- Clear mid-stream: 3 entries queued in each FIFO, pulse clear_in -> next cycle cdb_valid=0, both full=0, and no stale entry is ever broadcast afterwards.
- Pause: rdy_in=0 for 3 cycles with entries queued -> cdb_* hold, full flags=1, inputs ignored; the stream resumes unchanged once rdy_in=1.
